vmx_axi_mem_slave: RTL
======================

Name: vmx_axi_mem_slave

Overview:
AXI4 full-protocol slave backed by an internal word-addressed memory. It is the responder end of the VMX engine's M_AXI DMA master and serves that master's single- and multi-beat INCR read and write bursts. It is used as an on-fabric scratch memory and as the synthesizable DMA target in system benches. Read and write channels run independently and concurrently.

Parameters:
- C_S_AXI_ID_WIDTH, 1, width of AWID/BID/ARID/RID.
- C_S_AXI_ADDR_WIDTH, 32, byte address width.
- C_S_AXI_DATA_WIDTH, 32, data width. Only 32 is supported.
- MEM_DEPTH_LOG2, 10, log2 of memory depth in 32-bit words (default 1024 words = 4 KB).
- C_BASE_ADDR, 32'h0000_0000, byte base address of the memory window.

Ports:
S_AXI_ACLK  input  1  clock
S_AXI_ARESETN  input  1  reset, asynchronous, active-low
S_AXI_AWID  input  ID  write ID
S_AXI_AWADDR  input  ADDR  write start byte address
S_AXI_AWLEN  input  8  beats minus 1
S_AXI_AWSIZE  input  3  beat size
S_AXI_AWBURST  input  2  burst type
S_AXI_AWVALID  input  1  write address valid
S_AXI_AWREADY  output  1  write address ready
S_AXI_WDATA  input  32  write data
S_AXI_WSTRB  input  4  byte enables
S_AXI_WLAST  input  1  last write beat
S_AXI_WVALID  input  1  write data valid
S_AXI_WREADY  output  1  write data ready
S_AXI_BID  output  ID  response ID
S_AXI_BRESP  output  2  write response
S_AXI_BVALID  output  1  response valid
S_AXI_BREADY  input  1  response ready
S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARVALID  input  as AW equivalents  read address channel
S_AXI_ARREADY  output  1  read address ready
S_AXI_RID  output  ID  read ID
S_AXI_RDATA  output  32  read data
S_AXI_RRESP  output  2  read response
S_AXI_RLAST  output  1  last read beat
S_AXI_RVALID  output  1  read data valid
S_AXI_RREADY  input  1  read data ready

Behaviour:
- Clock and reset: one clock, S_AXI_ACLK. S_AXI_ARESETN is asynchronous and active-low.
- Reset values: all outputs are 0, both FSMs go to IDLE. Memory contents are not reset and are preserved across reset. A reset mid-burst aborts the burst immediately with no response issued.
- Write FSM states are W_IDLE, W_DATA and W_RESP.
  - W_IDLE: AWREADY=1 (registered; asserts the first cycle after reset release). An AW handshake latches ID, address, LEN and an error flag, drops AWREADY and moves to W_DATA.
  - W_DATA: WREADY=1. On each W handshake:
    - If the beat is legal, write the lanes selected by WSTRB to the memory word.
    - The beat counter increments.
    - For INCR or WRAP bursts the address advances by 4. WRAP is treated as INCR. For FIXED bursts the address holds.
  - Leaving W_DATA: on the handshake where the counter equals LEN, or where WLAST=1, whichever comes first, drop WREADY and move to W_RESP.
  - W_RESP: BVALID=1 and BID=the latched ID. The FSM holds there until BREADY, then returns to W_IDLE with AWREADY=1 the next cycle.
- Write BRESP encoding:
  - OKAY (00) by default.
  - SLVERR (10) if AWSIZE!=3'b010, AWBURST==2'b11, or WLAST does not coincide with the final beat. An early WLAST ends the burst.
  - DECERR (11) if any beat address lies outside [C_BASE_ADDR, C_BASE_ADDR+4*2^MEM_DEPTH_LOG2). Out-of-range beats are not written.
  - SLVERR outranks DECERR.
  - An AWSIZE or AWBURST error suppresses all writes for the burst.
- Read FSM states are R_IDLE, R_ADDR and R_DATA.
  - R_IDLE: ARREADY=1. An AR handshake latches the request, drops ARREADY and moves to R_ADDR.
  - R_ADDR: the memory is read with one-cycle registered latency. The first RVALID appears 2 cycles after the AR handshake.
  - R_DATA: RVALID=1 with RDATA, RRESP, RID and RLAST stable until RREADY. RLAST=1 only on beat LEN.
  - On RREADY with more beats left, the address advances per the write-address rules and the FSM returns to R_ADDR. RVALID deasserts for 1 cycle between beats.
  - After the last beat the FSM returns to R_IDLE.
  - Read errors use the write encoding: SLVERR for bad ARSIZE/ARBURST, DECERR per out-of-range beat. An errored beat returns RDATA=0.
- Word index is (addr - C_BASE_ADDR)[MEM_DEPTH_LOG2+1:2]. Address bits [1:0] are ignored.
- Read/write collision: a read and a write to the same word in the same cycle return the old data (read-first).
- Outstanding transactions: one per direction. The AW and AR channels are not accepted while their own burst is in flight.

Test Plan:
1. Single-beat write:
   - Stimulus: write 0x10, LEN=0, WDATA=0x12345678, WSTRB=F. Then read 0x10, LEN=0.
   - Required: BRESP=00, BID=0; read returns RDATA=0x12345678 with RLAST=1, RRESP=00.
2. DMA-style 2-beat burst:
   - Stimulus: write 0x100, LEN=1, data 0x87654321 then 0x12345678. Read back with LEN=1.
   - Required: both words returned in order; RLAST=1 on beat 2 only; a single B response.
3. Partial write:
   - Stimulus: preload 0x20=0xFFFFFFFF, then write 0x0000ABCD with WSTRB=4'b0011.
   - Required: readback 0xFFFFABCD.
4. Backpressure:
   - Stimulus: hold BREADY low for 5 cycles; toggle RREADY every other cycle during a LEN=3 read.
   - Required: BVALID/BID stay held; RDATA/RLAST stay stable while RVALID and not RREADY; all 4 beats returned correctly.
5. Errors:
   - Stimulus: write 0x1000 (default depth); write with WLAST on beat 0 of LEN=1; read 0x1000.
   - Required: BRESP=11 with memory unchanged; BRESP=10; RRESP=11 with RDATA=0.
6. Reset mid-burst:
   - Stimulus: assert S_AXI_ARESETN=0 after beat 1 of a LEN=3 read; release it and read again.
   - Required: RVALID=0 immediately; the new read returns the preloaded data with memory intact.

Source files
------------

// File: rtl/vmx_axi_mem_slave.sv
// AXI4 slave backed by an internal word memory; serves single and multi-beat INCR bursts.
// Read and write channels are independent, one outstanding burst per direction.
module vmx_axi_mem_slave #(
   parameter int unsigned C_S_AXI_ID_WIDTH   = 1,
   parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
   parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
   parameter int unsigned MEM_DEPTH_LOG2     = 10,
   parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = '0
) (
   input  logic                          S_AXI_ACLK,
   input  logic                          S_AXI_ARESETN,
   input  logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_AWID,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
   input  logic [7:0]                    S_AXI_AWLEN,
   input  logic [2:0]                    S_AXI_AWSIZE,
   input  logic [1:0]                    S_AXI_AWBURST,
   input  logic                          S_AXI_AWVALID,
   output logic                          S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                          S_AXI_WLAST,
   input  logic                          S_AXI_WVALID,
   output logic                          S_AXI_WREADY,
   output logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_BID,
   output logic [1:0]                    S_AXI_BRESP,
   output logic                          S_AXI_BVALID,
   input  logic                          S_AXI_BREADY,
   input  logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_ARID,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
   input  logic [7:0]                    S_AXI_ARLEN,
   input  logic [2:0]                    S_AXI_ARSIZE,
   input  logic [1:0]                    S_AXI_ARBURST,
   input  logic                          S_AXI_ARVALID,
   output logic                          S_AXI_ARREADY,
   output logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_RID,
   output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
   output logic [1:0]                    S_AXI_RRESP,
   output logic                          S_AXI_RLAST,
   output logic                          S_AXI_RVALID,
   input  logic                          S_AXI_RREADY
);

   localparam int unsigned AW    = C_S_AXI_ADDR_WIDTH;
   localparam int unsigned DW    = C_S_AXI_DATA_WIDTH;
   localparam int unsigned IW    = C_S_AXI_ID_WIDTH;
   localparam int          SW    = C_S_AXI_DATA_WIDTH / 8;
   localparam int unsigned Depth = 2 ** MEM_DEPTH_LOG2;

   localparam logic [1:0] RespOkay   = 2'b00;
   localparam logic [1:0] RespSlvErr = 2'b10;
   localparam logic [1:0] RespDecErr = 2'b11;

   typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
   typedef enum logic [1:0] {RIdle, RAddr, RData} r_state_e;

   function automatic logic in_win(input logic [AW-1:0] addr);
      logic [AW-1:0] off;
      off = addr - C_BASE_ADDR;
      return (addr >= C_BASE_ADDR) && ((off >> (MEM_DEPTH_LOG2 + 2)) == '0);
   endfunction

   function automatic logic [MEM_DEPTH_LOG2-1:0] word_idx(input logic [AW-1:0] addr);
      return MEM_DEPTH_LOG2'((addr - C_BASE_ADDR) >> 2);
   endfunction

   function automatic logic bad_cfg(input logic [2:0] size, input logic [1:0] burst);
      return (size != 3'b010) || (burst == 2'b11);
   endfunction

   logic [DW-1:0] mem_q [Depth];

   // Holds the ready outputs low while in reset and for the release edge itself.
   logic active_q;

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) active_q <= 1'b0;
      else                active_q <= 1'b1;
   end

   // ---------------------------------------------------------------- write path
   w_state_e      w_state_q, w_state_d;
   logic [IW-1:0] wid_q, wid_d;
   logic [AW-1:0] waddr_q, waddr_d;
   logic [7:0]    wlen_q, wlen_d, wcnt_q, wcnt_d;
   logic          wcfg_err_q, wcfg_err_d, wfixed_q, wfixed_d;
   logic          wslv_q, wslv_d, wdec_q, wdec_d;
   logic          mem_we, w_in_win, w_last_cnt;
   logic [MEM_DEPTH_LOG2-1:0] w_idx;

   assign w_in_win   = in_win(waddr_q);
   assign w_idx      = word_idx(waddr_q);
   assign w_last_cnt = (wcnt_q == wlen_q);

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         w_state_q  <= WIdle;
         wid_q      <= '0;
         waddr_q    <= '0;
         wlen_q     <= '0;
         wcnt_q     <= '0;
         wcfg_err_q <= 1'b0;
         wfixed_q   <= 1'b0;
         wslv_q     <= 1'b0;
         wdec_q     <= 1'b0;
      end else begin
         w_state_q  <= w_state_d;
         wid_q      <= wid_d;
         waddr_q    <= waddr_d;
         wlen_q     <= wlen_d;
         wcnt_q     <= wcnt_d;
         wcfg_err_q <= wcfg_err_d;
         wfixed_q   <= wfixed_d;
         wslv_q     <= wslv_d;
         wdec_q     <= wdec_d;
      end
   end

   always_comb begin
      w_state_d  = w_state_q;
      wid_d      = wid_q;
      waddr_d    = waddr_q;
      wlen_d     = wlen_q;
      wcnt_d     = wcnt_q;
      wcfg_err_d = wcfg_err_q;
      wfixed_d   = wfixed_q;
      wslv_d     = wslv_q;
      wdec_d     = wdec_q;
      mem_we     = 1'b0;
      unique case (w_state_q)
         WIdle: begin
            if (S_AXI_AWVALID && active_q) begin
               wid_d      = S_AXI_AWID;
               waddr_d    = S_AXI_AWADDR;
               wlen_d     = S_AXI_AWLEN;
               wcnt_d     = '0;
               wcfg_err_d = bad_cfg(S_AXI_AWSIZE, S_AXI_AWBURST);
               wfixed_d   = (S_AXI_AWBURST == 2'b00);
               wslv_d     = 1'b0;
               wdec_d     = 1'b0;
               w_state_d  = WData;
            end
         end
         WData: begin
            if (S_AXI_WVALID) begin
               mem_we = !wcfg_err_q && w_in_win;
               wdec_d = wdec_q | !w_in_win;
               wcnt_d = wcnt_q + 8'd1;
               if (!wfixed_q) waddr_d = waddr_q + AW'(4);
               // Whichever of count or WLAST comes first closes the burst.
               if (w_last_cnt || S_AXI_WLAST) begin
                  wslv_d    = wslv_q | (w_last_cnt != S_AXI_WLAST);
                  w_state_d = WResp;
               end
            end
         end
         WResp: begin
            if (S_AXI_BREADY) w_state_d = WIdle;
         end
         default: w_state_d = WIdle;
      endcase
   end

   always_comb begin
      S_AXI_AWREADY = active_q && (w_state_q == WIdle);
      S_AXI_WREADY  = (w_state_q == WData);
      S_AXI_BVALID  = (w_state_q == WResp);
      S_AXI_BID     = wid_q;
      if (wcfg_err_q || wslv_q) S_AXI_BRESP = RespSlvErr;
      else if (wdec_q)          S_AXI_BRESP = RespDecErr;
      else                      S_AXI_BRESP = RespOkay;
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (mem_we) begin
         for (int b = 0; b < SW; b++) begin
            if (S_AXI_WSTRB[b]) mem_q[w_idx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
         end
      end
   end

   // ----------------------------------------------------------------- read path
   r_state_e      r_state_q, r_state_d;
   logic [IW-1:0] rid_q, rid_d;
   logic [AW-1:0] raddr_q, raddr_d;
   logic [7:0]    rlen_q, rlen_d, rcnt_q, rcnt_d;
   logic          rcfg_err_q, rcfg_err_d, rfixed_q, rfixed_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic [1:0]    rresp_q, rresp_d;
   logic          r_in_win;
   logic [MEM_DEPTH_LOG2-1:0] r_idx;

   assign r_in_win = in_win(raddr_q);
   assign r_idx    = word_idx(raddr_q);

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         r_state_q  <= RIdle;
         rid_q      <= '0;
         raddr_q    <= '0;
         rlen_q     <= '0;
         rcnt_q     <= '0;
         rcfg_err_q <= 1'b0;
         rfixed_q   <= 1'b0;
         rdata_q    <= '0;
         rresp_q    <= RespOkay;
      end else begin
         r_state_q  <= r_state_d;
         rid_q      <= rid_d;
         raddr_q    <= raddr_d;
         rlen_q     <= rlen_d;
         rcnt_q     <= rcnt_d;
         rcfg_err_q <= rcfg_err_d;
         rfixed_q   <= rfixed_d;
         rdata_q    <= rdata_d;
         rresp_q    <= rresp_d;
      end
   end

   // The memory write lands via NBA, so a same-cycle read of that word sees old data.
   always_comb begin
      r_state_d  = r_state_q;
      rid_d      = rid_q;
      raddr_d    = raddr_q;
      rlen_d     = rlen_q;
      rcnt_d     = rcnt_q;
      rcfg_err_d = rcfg_err_q;
      rfixed_d   = rfixed_q;
      rdata_d    = rdata_q;
      rresp_d    = rresp_q;
      unique case (r_state_q)
         RIdle: begin
            if (S_AXI_ARVALID && active_q) begin
               rid_d      = S_AXI_ARID;
               raddr_d    = S_AXI_ARADDR;
               rlen_d     = S_AXI_ARLEN;
               rcnt_d     = '0;
               rcfg_err_d = bad_cfg(S_AXI_ARSIZE, S_AXI_ARBURST);
               rfixed_d   = (S_AXI_ARBURST == 2'b00);
               r_state_d  = RAddr;
            end
         end
         RAddr: begin
            r_state_d = RData;
            if (rcfg_err_q) begin
               rdata_d = '0;
               rresp_d = RespSlvErr;
            end else if (!r_in_win) begin
               rdata_d = '0;
               rresp_d = RespDecErr;
            end else begin
               rdata_d = mem_q[r_idx];
               rresp_d = RespOkay;
            end
         end
         RData: begin
            if (S_AXI_RREADY) begin
               if (rcnt_q == rlen_q) begin
                  r_state_d = RIdle;
               end else begin
                  rcnt_d    = rcnt_q + 8'd1;
                  if (!rfixed_q) raddr_d = raddr_q + AW'(4);
                  r_state_d = RAddr;
               end
            end
         end
         default: r_state_d = RIdle;
      endcase
   end

   always_comb begin
      S_AXI_ARREADY = active_q && (r_state_q == RIdle);
      S_AXI_RVALID  = (r_state_q == RData);
      S_AXI_RLAST   = (r_state_q == RData) && (rcnt_q == rlen_q);
      S_AXI_RID     = rid_q;
      S_AXI_RDATA   = rdata_q;
      S_AXI_RRESP   = rresp_q;
   end

endmodule
